// File: rtl/dmem_responder_pkg.sv
// Shared constants and helpers for the data-memory responder: default geometry,
// MMIO window placement, register offsets and the error-counter saturation value.
package dmem_responder_pkg;

    localparam int          DEPTH_LOG2_DEF = 8;
    localparam logic [31:0] MMIO_BASE_DEF  = 32'hFFFF_0000;

    localparam logic [3:0]  OFF_CNT  = 4'h0;
    localparam logic [3:0]  OFF_LED  = 4'h4;
    localparam logic [3:0]  OFF_STAT = 4'h8;
    localparam logic [3:0]  OFF_RSVD = 4'hC;

    localparam logic [7:0]  ERR_SAT  = 8'hFF;

    typedef enum logic [1:0] {
        REGION_NONE = 2'd0,
        REGION_RAM  = 2'd1,
        REGION_MMIO = 2'd2
    } region_e;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == ERR_SAT) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// One-entry posted write buffer in front of a combinationally read word array.
// Loads that hit the pending entry are forwarded so the buffer is invisible to software.
module dmem_wbuf
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [DEPTH_LOG2-1:0] i_wr_idx,
    input  logic [31:0]           i_wr_data,
    input  logic [DEPTH_LOG2-1:0] i_rd_idx,
    output logic [31:0]           o_rd_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           r_mem [0:DEPTH-1];
    logic                  r_valid;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [31:0]           r_data;
    logic                  w_fwd_hit;

    // Array is left unreset; r_valid is cleared asynchronously, so a pending
    // entry caught by reset never reaches the array.
    always_ff @(posedge clk) begin
        if (r_valid) begin
            r_mem[r_idx] <= r_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_data  <= '0;
        end else begin
            r_valid <= i_wr_en;
            if (i_wr_en) begin
                r_idx  <= i_wr_idx;
                r_data <= i_wr_data;
            end
        end
    end

    assign w_fwd_hit = r_valid && (r_idx == i_rd_idx);
    assign o_rd_data = w_fwd_hit ? r_data : r_mem[i_rd_idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the pipeline mem stage: decodes RAM / MMIO / unmapped,
// owns the MMIO registers (cycle counter, LEDs, error status) and the load mux.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        AddrErrM,
    output logic [15:0] LedOut
);

    localparam int RAM_HI_LSB = DEPTH_LOG2 + 2;

    region_e               w_region;
    logic                  w_ram_hit;
    logic                  w_mmio_hit;
    logic                  w_misaligned;
    logic                  w_store_ok;
    logic                  w_store_err;
    logic                  w_ram_we;
    logic                  w_mmio_we;
    logic [3:0]            w_off;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [31:0]           w_ram_rdata;
    logic [31:0]           w_mmio_rdata;

    logic [31:0]           r_cnt;
    logic [15:0]           r_led;
    logic [7:0]            r_err_cnt;

    assign w_ram_hit    = ((ALUOutM >> RAM_HI_LSB) == 32'd0);
    assign w_mmio_hit   = (ALUOutM[31:4] == MMIO_BASE[31:4]);
    assign w_misaligned = |ALUOutM[1:0];
    assign w_off        = ALUOutM[3:0];
    assign w_idx        = ALUOutM[DEPTH_LOG2+1:2];

    always_comb begin
        w_region = REGION_NONE;
        if (w_ram_hit) begin
            w_region = REGION_RAM;
        end else if (w_mmio_hit) begin
            w_region = REGION_MMIO;
        end
    end

    assign AddrErrM    = w_misaligned || (w_region == REGION_NONE);
    assign w_store_ok  = MemWriteM && !AddrErrM;
    assign w_store_err = MemWriteM && AddrErrM;
    assign w_ram_we    = w_store_ok && (w_region == REGION_RAM);
    assign w_mmio_we   = w_store_ok && (w_region == REGION_MMIO);

    dmem_wbuf #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_wbuf (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_ram_we),
        .i_wr_idx  (w_idx),
        .i_wr_data (WriteDataM),
        .i_rd_idx  (w_idx),
        .o_rd_data (w_ram_rdata)
    );

    // A counter store takes effect instead of that cycle's increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= 32'd0;
            r_led     <= 16'd0;
            r_err_cnt <= 8'd0;
        end else begin
            if (w_mmio_we && (w_off == OFF_CNT)) begin
                r_cnt <= WriteDataM;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end

            if (w_mmio_we && (w_off == OFF_LED)) begin
                r_led <= WriteDataM[15:0];
            end

            if (w_store_err) begin
                r_err_cnt <= sat_inc(r_err_cnt);
            end else if (w_mmio_we && (w_off == OFF_STAT)) begin
                r_err_cnt <= 8'd0;
            end
        end
    end

    always_comb begin
        w_mmio_rdata = 32'd0;
        case (w_off)
            OFF_CNT:  w_mmio_rdata = r_cnt;
            OFF_LED:  w_mmio_rdata = {16'd0, r_led};
            OFF_STAT: w_mmio_rdata = {24'd0, r_err_cnt};
            OFF_RSVD: w_mmio_rdata = 32'd0;
            default:  w_mmio_rdata = 32'd0;
        endcase
    end

    always_comb begin
        ReadDataM = 32'd0;
        if (!AddrErrM) begin
            if (w_region == REGION_RAM) begin
                ReadDataM = w_ram_rdata;
            end else begin
                ReadDataM = w_mmio_rdata;
            end
        end
    end

    assign LedOut = r_led;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: the stimulus queues expected responses,
// a negedge monitor pops and compares them against the live DUT outputs.
module tb_dmem_responder;

    localparam logic [31:0] MB = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        AddrErrM;
    logic [15:0] LedOut;

    typedef struct {
        int          tag;
        bit          chk_rd;
        logic [31:0] rd;
        bit          err;
        bit          chk_led;
        logic [15:0] led;
    } exp_t;

    exp_t sb_q[$];
    bit   tb_chk = 1'b0;
    int   n_vec  = 0;
    int   n_bad  = 0;
    int   tag    = 0;

    always #5 clk = ~clk;

    dmem_responder u_dut (
        .clk        (clk),
        .rst        (rst),
        .MemWriteM  (MemWriteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .AddrErrM   (AddrErrM),
        .LedOut     (LedOut)
    );

    // Drive one cycle of stimulus, queue its expectation, then advance past the edge.
    task automatic step(input bit we, input logic [31:0] a, input logic [31:0] d,
                        input bit chk_rd, input logic [31:0] exp_rd, input bit exp_err,
                        input bit chk_led, input logic [15:0] exp_led);
        exp_t e;
        MemWriteM  = we;
        ALUOutM    = a;
        WriteDataM = d;
        tag++;
        tb_chk = 1'b1;
        e.tag = tag; e.chk_rd = chk_rd; e.rd = exp_rd; e.err = exp_err;
        e.chk_led = chk_led; e.led = exp_led;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        tb_chk = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp_rd, input bit exp_err);
        step(1'b0, a, 32'd0, 1'b1, exp_rd, exp_err, 1'b0, 16'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input bit exp_err);
        step(1'b1, a, d, 1'b0, 32'd0, exp_err, 1'b0, 16'd0);
    endtask

    always @(negedge clk) begin
        if (tb_chk) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL scoreboard_empty tag=%0d: got no entry, required one", tag);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                n_vec++;
                if (AddrErrM !== e.err) begin
                    n_bad++;
                    $display("FAIL addr_err tag=%0d addr=%h: got %b required %b", e.tag, ALUOutM, AddrErrM, e.err);
                end
                if (e.chk_rd) begin
                    n_vec++;
                    if (ReadDataM !== e.rd) begin
                        n_bad++;
                        $display("FAIL read_data tag=%0d addr=%h: got %h required %h", e.tag, ALUOutM, ReadDataM, e.rd);
                    end
                end
                if (e.chk_led) begin
                    n_vec++;
                    if (LedOut !== e.led) begin
                        n_bad++;
                        $display("FAIL led_out tag=%0d: got %h required %h", e.tag, LedOut, e.led);
                    end
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        MemWriteM  = 1'b0;
        ALUOutM    = 32'd0;
        WriteDataM = 32'd0;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state: status 0, LEDs dark, counter held at 0
        step(1'b0, MB + 32'h8, 32'd0, 1'b1, 32'd0, 1'b0, 1'b1, 16'h0000);
        rst = 1'b1;
        rd(MB + 32'h0, 32'd0, 1'b0);
        rd(MB + 32'h0, 32'd1, 1'b0);
        rd(MB + 32'h4, 32'd0, 1'b0);

        // Store then forwarded load, then array load
        wr(32'h10, 32'hDEAD_BEEF, 1'b0);
        rd(32'h10, 32'hDEAD_BEEF, 1'b0);
        rd(32'h10, 32'hDEAD_BEEF, 1'b0);

        // Back-to-back stores to one index
        wr(32'h20, 32'h0000_1111, 1'b0);
        step(1'b1, 32'h20, 32'h0000_2222, 1'b1, 32'h0000_1111, 1'b0, 1'b0, 16'd0);
        rd(32'h20, 32'h0000_2222, 1'b0);
        rd(32'h20, 32'h0000_2222, 1'b0);

        // Errant stores: misaligned and unmapped
        wr(32'h13, 32'h1234_5678, 1'b1);
        wr(32'h0000_1000, 32'h1234_5678, 1'b1);
        rd(MB + 32'h8, 32'h2, 1'b0);
        rd(32'h10, 32'hDEAD_BEEF, 1'b0);
        rd(32'h12, 32'd0, 1'b1);
        rd(32'h0000_1000, 32'd0, 1'b1);
        rd(MB - 32'h4, 32'd0, 1'b1);

        // Reserved MMIO slot: reads 0, store ignored and not an error
        rd(MB + 32'hC, 32'd0, 1'b0);
        wr(MB + 32'hC, 32'hFFFF_FFFF, 1'b0);
        rd(MB + 32'hC, 32'd0, 1'b0);
        rd(MB + 32'h8, 32'h2, 1'b0);

        // Status store clears the error counter
        wr(MB + 32'h8, 32'h0, 1'b0);
        rd(MB + 32'h8, 32'h0, 1'b0);

        // Top RAM word and first unmapped byte above it
        wr(32'h3FC, 32'h1357_9BDF, 1'b0);
        rd(32'h3FC, 32'h1357_9BDF, 1'b0);
        rd(32'h3FC, 32'h1357_9BDF, 1'b0);
        rd(32'h400, 32'd0, 1'b1);

        // Cycle counter load and wrap
        wr(MB + 32'h0, 32'hFFFF_FFFE, 1'b0);
        rd(MB + 32'h0, 32'hFFFF_FFFE, 1'b0);
        rd(MB + 32'h0, 32'hFFFF_FFFF, 1'b0);
        rd(MB + 32'h0, 32'h0000_0000, 1'b0);

        // LED register
        wr(MB + 32'h4, 32'hABCD_1234, 1'b0);
        step(1'b0, MB + 32'h4, 32'd0, 1'b1, 32'h0000_1234, 1'b0, 1'b1, 16'h1234);

        // Pending store dropped by reset; earlier committed value survives
        wr(32'h30, 32'h0000_AAAA, 1'b0);
        rd(32'h30, 32'h0000_AAAA, 1'b0);
        wr(32'h30, 32'h0000_BBBB, 1'b0);
        rst = 1'b0;
        step(1'b0, 32'h30, 32'd0, 1'b1, 32'h0000_AAAA, 1'b0, 1'b1, 16'h0000);
        rst = 1'b1;
        rd(32'h30, 32'h0000_AAAA, 1'b0);
        rd(MB + 32'h8, 32'h0, 1'b0);
        wr(32'h30, 32'h0000_0005, 1'b0);
        rd(32'h30, 32'h0000_0005, 1'b0);
        rd(32'h30, 32'h0000_0005, 1'b0);

        // Error counter saturation
        for (int i = 0; i < 254; i++) begin
            MemWriteM = 1'b1; ALUOutM = 32'h0000_1000; WriteDataM = 32'd0;
            @(posedge clk);
            #1;
        end
        rd(MB + 32'h8, 32'hFE, 1'b0);
        for (int i = 0; i < 46; i++) begin
            MemWriteM = 1'b1; ALUOutM = 32'h0000_1001; WriteDataM = 32'd0;
            @(posedge clk);
            #1;
        end
        rd(MB + 32'h8, 32'hFF, 1'b0);
        rd(32'h10, 32'hDEAD_BEEF, 1'b0);

        MemWriteM = 1'b0;
        repeat (2) @(posedge clk);
        n_vec++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending entries, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, log2 of RAM depth in 32-bit words (256 words, byte range 0x0000_0000..0x0000_03FF).
REQ-002 Parameter MMIO_BASE, default 32'hFFFF_0000, base of the 16-byte MMIO window.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 MemWriteM  input  1  store strobe from the pipeline mem stage.
REQ-006 ALUOutM  input  32  byte address from the mem stage.
REQ-007 WriteDataM  input  32  store data.
REQ-008 ReadDataM  output  32  load data, combinational from the current ALUOutM.
REQ-009 AddrErrM  output  1  combinational flag: current address is misaligned or unmapped.
REQ-010 LedOut  output  16  MMIO LED register contents.

Function
REQ-011 Address decode: RAM hit when ALUOutM[31:DEPTH_LOG2+2]==0; MMIO hit when ALUOutM[31:4]==MMIO_BASE[31:4]; anything else is unmapped.
REQ-012 AddrErrM SHALL be 1 when ALUOutM[1:0]!=0 or the address is unmapped; otherwise 0.
REQ-013 A store (MemWriteM=1, AddrErrM=1) SHALL change no state except err_cnt.
REQ-014 RAM store SHALL be captured in a one-entry write buffer {valid, index, data} at the edge, and committed to the array at the next edge.
REQ-015 Commit and a new capture on the same edge SHALL both occur; the new store occupies the buffer.
REQ-016 RAM load with buffer valid and matching index SHALL return buffer data (forwarding); otherwise it SHALL return array[index].
REQ-017 Back-to-back stores to the same index: the later value SHALL win in both the buffer and the array.
REQ-018 MMIO +0x0 (cycle counter, 32 bit): increments by 1 every cycle and wraps 0xFFFFFFFF->0; a store loads WriteDataM, and increments resume the following cycle.
REQ-019 MMIO +0x4 (LED): a store writes WriteDataM[15:0]; a read returns {16'b0, led}; LedOut=led.
REQ-020 MMIO +0x8 (status): a read returns {24'b0, err_cnt}; any store clears err_cnt.
REQ-021 err_cnt (8 bit) SHALL increment on each errant store cycle and saturate at 255.
REQ-022 MMIO +0xC SHALL read 0, ignore stores, and raise no error.
REQ-023 An errant address SHALL read 32'h0000_0000.

Reset
REQ-024 On rst low, asynchronously: buffer valid=0, cycle counter=0, led=0, err_cnt=0, and therefore LedOut=0.
REQ-025 A store pending in the buffer at reset SHALL be discarded, not committed.
REQ-026 RAM array contents SHALL NOT be reset; a word that has never been written reads as undefined.
REQ-027 Operation SHALL resume on the first rising edge after rst returns high.

Structure
REQ-028 The shared package/header SHALL hold DEPTH_LOG2 default, MMIO_BASE, the offsets CNT=0x0, LED=0x4, STAT=0x8, and ERR_SAT=8'hFF.
REQ-029 The write buffer with forwarding compare SHALL be one sub-module, dmem_wbuf; decode, MMIO registers and the read mux stay in dmem_responder.
REQ-030 Target size is 120-400 lines RTL; no latches; the array is inferable as distributed RAM.

Verification
REQ-031 Store 0xDEADBEEF @0x10, then load @0x10 the next cycle (forwarded) and two cycles later (array) -> both return 0xDEADBEEF.
REQ-032 Stores 0x1111 then 0x2222 @0x20 on consecutive cycles, then load @0x20 -> returns 0x2222.
REQ-033 Store @0x13 (misaligned) and store @0x0000_1000 (unmapped) -> AddrErrM=1 for each; status reads 0x2; RAM at 0x10 unchanged.
REQ-034 Store 0xFFFFFFFE to counter, read over 3 cycles -> 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
REQ-035 Store 0xABCD1234 to LED -> LedOut=0x1234 and read returns 0x00001234; assert rst mid-run -> LedOut=0 immediately.
REQ-036 Store @0x30 followed by rst low on the next cycle -> buffer discarded; after rewriting 0x30 with 0x5, load returns 0x5; 300 errant stores -> err_cnt=255.
